// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- multi-cycle ALU for the CPU execute stage.
//
// The control unit starts an operation with a START/BUSY/DONE handshake and
// stalls the pipeline while BUSY is high. Logic ops and add/subtract finish
// one edge after acceptance. Shifts and rotates step 1 bit per cycle. MUL is
// an unsigned shift-add multiplier that returns the full double-width product.
//
// Ports:
//   CLK        in   system clock, rising edge active
//   RESET      in   synchronous, active-high reset
//   START      in   request; accepted only at an edge where BUSY is low
//   SELECT     in   [3:0] opcode, captured with START
//   DATA1      in   [WIDTH-1:0] operand A, captured with START
//   DATA2      in   [WIDTH-1:0] operand B or shift amount, captured with START
//   BUSY       out  high from the accept edge until the completion edge
//   DONE       out  one-cycle pulse in the cycle after the completion edge
//   RESULT     out  [WIDTH-1:0] result; holds until the next completion
//   RESULT_HI  out  [WIDTH-1:0] upper half of a MUL product, else 0
//   ZERO       out  RESULT == 0, updated together with RESULT
// -----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [3:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             ZERO
);

  localparam int LOGW = $clog2(WIDTH);

  localparam logic [3:0] OP_MOV = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1001;

  // WIDTH expressed in the counter width and in the operand width.
  localparam logic [CNTW-1:0]  W_CNT  = CNTW'(WIDTH);
  localparam logic [WIDTH-1:0] W_OPND = WIDTH'(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [3:0]       op;        // opcode of the running operation
  logic [WIDTH-1:0] opa;       // operand A / multiplicand
  logic [WIDTH-1:0] opb;       // operand B for the single-step ops
  logic [WIDTH-1:0] acc_hi;    // upper half of the MUL accumulator
  logic [WIDTH-1:0] acc_lo;    // shift working value / lower MUL half
  logic [CNTW-1:0]  cnt;       // remaining iteration steps

  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] fin_lo;
  logic [WIDTH-1:0] fin_hi;

  // Number of RUN steps before the completion edge.
  // Plain shifts saturate at WIDTH because every bit has gone by then.
  // A rotate by a multiple of WIDTH is the identity, so only B mod WIDTH
  // steps are needed.
  function automatic logic [CNTW-1:0] iter_count(input logic [3:0]       sel,
                                                 input logic [WIDTH-1:0] b);
    logic [CNTW-1:0] k;
    k = {CNTW{1'b0}};
    case (sel)
      OP_SRL, OP_SLL, OP_SRA: begin
        if (b >= W_OPND) begin
          k = W_CNT;
        end else begin
          k = CNTW'(b);
        end
      end
      OP_ROR:  k = {1'b0, b[LOGW-1:0]};
      OP_MUL:  k = W_CNT;
      default: k = {CNTW{1'b0}};
    endcase
    return k;
  endfunction

  // Result of the ops that need no iteration. Invalid opcodes give 0.
  function automatic logic [WIDTH-1:0] single_result(input logic [3:0]       sel,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    case (sel)
      OP_MOV:  r = b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // MUL partial sum: add the multiplicand when the current multiplier bit is
  // set. The extra bit keeps the carry, which is shifted into acc_hi.
  always_comb begin
    mul_sum = {1'b0, acc_hi};
    if (acc_lo[0]) begin
      mul_sum = {1'b0, acc_hi} + {1'b0, opa};
    end else begin
      mul_sum = {1'b0, acc_hi};
    end
  end

  // One iteration step of the running shift, rotate or multiply.
  always_comb begin
    step_hi = acc_hi;
    step_lo = acc_lo;
    case (op)
      OP_SRL: step_lo = {1'b0, acc_lo[WIDTH-1:1]};
      OP_SLL: step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      OP_ROR: step_lo = {acc_lo[0], acc_lo[WIDTH-1:1]};
      OP_SRA: step_lo = {acc_lo[WIDTH-1], acc_lo[WIDTH-1:1]};
      OP_MUL: begin
        // {carry, acc_hi, acc_lo} shifted right by one. The used multiplier
        // bit drops out of acc_lo. A product bit enters acc_lo at the top.
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
      default: begin
        step_hi = acc_hi;
        step_lo = acc_lo;
      end
    endcase
  end

  // Values loaded into RESULT / RESULT_HI at the completion edge.
  always_comb begin
    fin_lo = {WIDTH{1'b0}};
    fin_hi = {WIDTH{1'b0}};
    case (op)
      OP_SRL, OP_SLL, OP_ROR, OP_SRA: begin
        fin_lo = acc_lo;
        fin_hi = {WIDTH{1'b0}};
      end
      OP_MUL: begin
        fin_lo = acc_lo;
        fin_hi = acc_hi;
      end
      default: begin
        fin_lo = single_result(op, opa, opb);
        fin_hi = {WIDTH{1'b0}};
      end
    endcase
  end

  // Control FSM, operand capture, iteration datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      op        <= 4'b0000;
      opa       <= {WIDTH{1'b0}};
      opb       <= {WIDTH{1'b0}};
      acc_hi    <= {WIDTH{1'b0}};
      acc_lo    <= {WIDTH{1'b0}};
      cnt       <= {CNTW{1'b0}};
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      RESULT    <= {WIDTH{1'b0}};
      RESULT_HI <= {WIDTH{1'b0}};
      ZERO      <= 1'b1;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            op     <= SELECT;
            opa    <= DATA1;
            opb    <= DATA2;
            cnt    <= iter_count(SELECT, DATA2);
            acc_hi <= {WIDTH{1'b0}};
            // MUL consumes the multiplier from acc_lo. Shifts work on A.
            if (SELECT == OP_MUL) begin
              acc_lo <= DATA2;
            end else begin
              acc_lo <= DATA1;
            end
            BUSY   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (cnt != {CNTW{1'b0}}) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - CNTW'(1);
          end else begin
            RESULT    <= fin_lo;
            RESULT_HI <= fin_hi;
            ZERO      <= (fin_lo == {WIDTH{1'b0}});
            DONE      <= 1'b1;
            BUSY      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
